// File: rtl/alu_operand_regfile_pkg.sv
// Purpose : shared constants for the ALU operand register bank (widths, flag bit positions, R0 index).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package alu_operand_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int FLAGS_W  = 3;

  // Flag bit positions inside flags_q; the ALU and branch logic use the same layout.
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // R0 reads as zero and ignores writes.
  localparam logic [ADDR_W-1:0] R0_IDX = '0;

endpackage

// File: rtl/alu_operand_regfile_read_port.sv
// Purpose : one registered operand read port with R0 zeroing and write-first bypass.
// Latency : 1 cycle from rd_addr_i to rd_data_o.
// Backpr. : rd_en_i low stalls the port and holds rd_data_o unchanged.
//
// Ports:
//   clk, rst_n   clock / async active-low reset
//   rd_en_i      fetch enable
//   rd_addr_i    source register
//   wr_en_i, wr_addr_i, wr_data_i   write port, observed for bypass
//   regs_i       current register array contents
//   rd_data_o    registered operand
//   bypass_o     combinational: this cycle's read address is being written
module regfile_read_port
  import alu_operand_regfile_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rd_en_i,
  input  logic [ADDR_W-1:0]                rd_addr_i,
  input  logic                             wr_en_i,
  input  logic [ADDR_W-1:0]                wr_addr_i,
  input  logic [DATA_W-1:0]                wr_data_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
  output logic [DATA_W-1:0]                rd_data_o,
  output logic                             bypass_o
);

  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Bypass never fires for R0, so a write to R0 cannot leak into the operand.
  assign bypass_o = wr_en_i && (wr_addr_i == rd_addr_i) && (rd_addr_i != R0_IDX);

  always_comb begin
    rd_data_d = regs_i[rd_addr_i];
    if (rd_addr_i == R0_IDX) begin
      rd_data_d = '0;
    end else if (bypass_o) begin
      rd_data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/alu_operand_regfile.sv
// Purpose : ALU operand register bank: NUM_REGS x DATA_W, two registered read ports, one write port, latched C/Z/N flags.
// Latency : 1 cycle read (write-first bypass on the same edge); writes and flags visible after 1 edge.
// Backpr. : rd_en low stalls both read outputs; no flow control on writes or flags.
//
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   rd_en, rd_addr_a, rd_addr_b operand fetch request
//   rd_data_a, rd_data_b        registered operands to ALU A / B
//   wr_en, wr_addr, wr_data     write port (ALU result or load data)
//   flag_we, c_in, z_in, n_in   flag capture
//   flags_q                     latched {C,Z,N}
//   wr_busy_hit                 previous fetch used bypass data on either port
module alu_operand_regfile
  import alu_operand_regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr_a,
  input  logic [ADDR_W-1:0]  rd_addr_b,
  output logic [DATA_W-1:0]  rd_data_a,
  output logic [DATA_W-1:0]  rd_data_b,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               flag_we,
  input  logic               c_in,
  input  logic               z_in,
  input  logic               n_in,
  output logic [FLAGS_W-1:0] flags_q,
  output logic               wr_busy_hit
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [FLAGS_W-1:0]              flags_d;
  logic [FLAGS_W-1:0]              flags_r_q;
  logic                            busy_hit_d;
  logic                            busy_hit_q;
  logic                            bypass_a;
  logic                            bypass_b;
  logic                            wr_ok;

  assign wr_ok = wr_en && (wr_addr != R0_IDX);

  // Entry 0 is reset to zero and never written; the read ports also force it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_read_port u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr_a),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .regs_i    (regs_q),
    .rd_data_o (rd_data_a),
    .bypass_o  (bypass_a)
  );

  regfile_read_port u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr_b),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .regs_i    (regs_q),
    .rd_data_o (rd_data_b),
    .bypass_o  (bypass_b)
  );

  // Only a fetch that actually updates the outputs counts as a bypass hit.
  assign busy_hit_d = rd_en && (bypass_a || bypass_b);

  always_comb begin
    flags_d = flags_r_q;
    if (flag_we) begin
      flags_d[FLAG_C] = c_in;
      flags_d[FLAG_Z] = z_in;
      flags_d[FLAG_N] = n_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r_q  <= '0;
      busy_hit_q <= 1'b0;
    end else begin
      flags_r_q  <= flags_d;
      busy_hit_q <= busy_hit_d;
    end
  end

  assign flags_q     = flags_r_q;
  assign wr_busy_hit = busy_hit_q;

endmodule

// File: tb/tb_alu_operand_regfile.sv
module tb_alu_operand_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flag_we, c_in, z_in, n_in;
  logic [2:0]  flags_q;
  logic        wr_busy_hit;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // mask bits: [3]=a [2]=b [1]=hit [0]=flags
  typedef struct {
    int          due;
    string       name;
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    logic        hit;
    logic [2:0]  fl;
  } exp_t;

  exp_t sb[$];

  alu_operand_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .flag_we     (flag_we),
    .c_in        (c_in),
    .z_in        (z_in),
    .n_in        (n_in),
    .flags_q     (flags_q),
    .wr_busy_hit (wr_busy_hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, req);
    end
  endtask

  task automatic check_entry(input exp_t e);
    if (e.mask[3]) cmp(e.name, "rd_data_a", rd_data_a, e.a);
    if (e.mask[2]) cmp(e.name, "rd_data_b", rd_data_b, e.b);
    if (e.mask[1]) cmp(e.name, "wr_busy_hit", {31'd0, wr_busy_hit}, {31'd0, e.hit});
    if (e.mask[0]) cmp(e.name, "flags_q", {29'd0, flags_q}, {29'd0, e.fl});
  endtask

  // Queue an expectation for the outputs after the next clock edge.
  task automatic expect_next(input string name, input logic [3:0] mask, input logic [31:0] a,
                             input logic [31:0] b, input logic hit, input logic [2:0] fl);
    exp_t e;
    e.due = cyc + 1; e.name = name; e.mask = mask;
    e.a = a; e.b = b; e.hit = hit; e.fl = fl;
    sb.push_back(e);
  endtask

  // Immediate check, used for asynchronous reset where no clock edge is involved.
  task automatic check_now(input string name, input logic [3:0] mask, input logic [31:0] a,
                           input logic [31:0] b, input logic hit, input logic [2:0] fl);
    exp_t e;
    e.due = cyc; e.name = name; e.mask = mask;
    e.a = a; e.b = b; e.hit = hit; e.fl = fl;
    check_entry(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic [3:0] aa, input logic [3:0] ab,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd);
    rd_en = re; rd_addr_a = aa; rd_addr_b = ab;
    wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  task automatic drive_flags(input logic fwe, input logic c, input logic z, input logic n);
    flag_we = fwe; c_in = c; z_in = z; n_in = n;
  endtask

  // Monitor: outputs are sampled on the falling edge, well away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check_entry(e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0);
    drive_flags(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check_now("reset_init", 4'b1111, 32'd0, 32'd0, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Freshly reset register reads back zero.
    drive(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 32'd0);
    expect_next("read_r5_after_reset", 4'b1111, 32'd0, 32'd0, 1'b0, 3'b000);
    tick();

    // Basic operand fetch.
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 32'd3);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 32'd10);
    tick();
    drive(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0);
    expect_next("fetch_r1_r2", 4'b1110, 32'd3, 32'd10, 1'b0, 3'b000);
    tick();
    drive(1'b0, 4'd1, 4'd2, 1'b1, 4'd3, 32'd13);
    tick();
    drive(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 32'd0);
    expect_next("fetch_r3", 4'b1110, 32'd13, 32'd13, 1'b0, 3'b000);
    tick();

    // Same-edge bypass on both ports, then plain read of the written value.
    drive(1'b1, 4'd4, 4'd4, 1'b1, 4'd4, 32'hDEADBEEF);
    expect_next("bypass_both", 4'b1110, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b000);
    tick();
    drive(1'b1, 4'd4, 4'd4, 1'b0, 4'd0, 32'd0);
    expect_next("r4_after_bypass", 4'b1110, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b000);
    tick();

    // Bypass on port B only; port A reads stored data.
    drive(1'b1, 4'd1, 4'd6, 1'b1, 4'd6, 32'h0000_0055);
    expect_next("bypass_b_only", 4'b1110, 32'd3, 32'h0000_0055, 1'b1, 3'b000);
    tick();

    // R0 writes are dropped and never bypass.
    drive(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 32'hFFFFFFFF);
    expect_next("r0_write_same_read", 4'b1110, 32'd0, 32'd0, 1'b0, 3'b000);
    tick();
    drive(1'b1, 4'd0, 4'd1, 1'b0, 4'd0, 32'd0);
    expect_next("r0_after_write", 4'b1110, 32'd0, 32'd3, 1'b0, 3'b000);
    tick();

    // Stall: outputs hold while rd_en is low, even across a write to the read address.
    drive(1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 32'd0);
    expect_next("pre_stall", 4'b1110, 32'd3, 32'd3, 1'b0, 3'b000);
    tick();
    drive(1'b0, 4'd1, 4'd2, 1'b1, 4'd1, 32'd7);
    expect_next("stall_hold", 4'b1110, 32'd3, 32'd3, 1'b0, 3'b000);
    tick();
    drive(1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 32'd0);
    expect_next("after_stall", 4'b1110, 32'd7, 32'd7, 1'b0, 3'b000);
    tick();

    // Flags capture and hold.
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0);
    drive_flags(1'b1, 1'b1, 1'b0, 1'b1);
    expect_next("flags_capture_101", 4'b0001, 32'd0, 32'd0, 1'b0, 3'b101);
    tick();
    drive_flags(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_next("flags_hold", 4'b0001, 32'd0, 32'd0, 1'b0, 3'b101);
      tick();
    end
    drive_flags(1'b1, 1'b0, 1'b1, 1'b1);
    expect_next("flags_capture_011", 4'b0001, 32'd0, 32'd0, 1'b0, 3'b011);
    tick();
    drive_flags(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) tick();

    // Asynchronous reset mid-sequence, with a write pending that must be discarded.
    drive(1'b1, 4'd7, 4'd7, 1'b1, 4'd5, 32'h0000_0099);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("reset_mid", 4'b1111, 32'd0, 32'd0, 1'b0, 3'b000);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 4'd5, 4'd1, 1'b0, 4'd0, 32'd0);
    expect_next("regs_cleared", 4'b1111, 32'd0, 32'd0, 1'b0, 3'b000);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
